// File: rtl/gelu_job_sequencer.sv
// Sequences one GELU job: streams len words from a source SRAM region through the
// fixed-latency GELU pipeline and writes results in order to a destination region.
module gelu_job_sequencer #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned GELU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    input  logic              hold,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              gelu_valid_in,
    output logic [DATA_W-1:0] gelu_data_in,
    input  logic              gelu_valid_out,
    input  logic [DATA_W-1:0] gelu_data_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    // A compliant GELU unit never holds more than GELU_LAT words at once.
    localparam int unsigned IF_W = $clog2(GELU_LAT + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [LEN_W-1:0]    written_q, written_d;
    logic [IF_W-1:0]     inflight_q, inflight_d;
    logic                aborted_q, aborted_d;
    logic                err_q, err_d;
    logic                vin_q, vin_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                rd_fire;
    logic                res_ok;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        issued_d   = issued_q;
        written_d  = written_q;
        inflight_d = inflight_q;
        aborted_d  = aborted_q;
        err_d      = err_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_fire    = 1'b0;

        // A result with nothing outstanding is flagged and otherwise dropped.
        res_ok = gelu_valid_out && (inflight_q != '0);
        if (gelu_valid_out && !res_ok) begin
            err_d = 1'b1;
        end

        if (res_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = dst_q + ADDR_W'(written_q);
            wr_data_d = gelu_data_out;
            written_d = written_q + LEN_W'(1);
        end

        case ({vin_q, res_ok})
            2'b10:   inflight_d = inflight_q + IF_W'(1);
            2'b01:   inflight_d = inflight_q - IF_W'(1);
            default: inflight_d = inflight_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d      = src_base;
                    dst_d      = dst_base;
                    len_d      = len;
                    issued_d   = '0;
                    written_d  = '0;
                    inflight_d = '0;
                    aborted_d  = 1'b0;
                    state_d    = (len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN;
                end else if (!hold) begin
                    rd_fire  = 1'b1;
                    issued_d = issued_q + LEN_W'(1);
                    if (issued_d == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Exit on next-cycle counters so DONE follows the final write directly.
                if ((inflight_d == '0) && !wr_en_d) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        vin_d = rd_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            written_q  <= '0;
            inflight_q <= '0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
            vin_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            written_q  <= written_d;
            inflight_q <= inflight_d;
            aborted_q  <= aborted_d;
            err_q      <= err_d;
            vin_q      <= vin_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign aborted       = (state_q == S_DONE) && aborted_q;
    assign err           = err_q;
    assign rd_en         = rd_fire;
    assign rd_addr       = src_q + ADDR_W'(issued_q);
    assign gelu_valid_in = vin_q;
    assign gelu_data_in  = rd_data;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;

endmodule

// File: tb/tb_gelu_job_sequencer.sv
// Bench for gelu_job_sequencer: SRAM and GELU pipeline models, directed job table,
// randomized jobs against an issue-list reference model, plus err and reset sequences.
`timescale 1ns/1ps
module tb_gelu_job_sequencer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 16;
    localparam int L      = 4;
    localparam int MAXC   = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [LEN_W-1:0]  len;
    logic              hold;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              gelu_valid_in;
    logic [DATA_W-1:0] gelu_data_in;
    logic              gelu_valid_out;
    logic [DATA_W-1:0] gelu_data_out;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always #5 clk = ~clk;

    gelu_job_sequencer #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .LEN_W   (LEN_W),
        .GELU_LAT(L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .src_base      (src_base),
        .dst_base      (dst_base),
        .len           (len),
        .hold          (hold),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .err           (err),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .gelu_valid_in (gelu_valid_in),
        .gelu_data_in  (gelu_data_in),
        .gelu_valid_out(gelu_valid_out),
        .gelu_data_out (gelu_data_out),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data)
    );

    function automatic logic [31:0] sram_word(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    function automatic logic [31:0] gelu_fn(input logic [31:0] x);
        return (x >> 1) ^ 32'h9E37_79B9;
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= sram_word(rd_addr);
    end

    // Stand-in GELU unit: fixed latency L, shares rst with the sequencer.
    logic [L-1:0]  pv;
    logic [31:0]   pd [L];
    logic          force_vo;
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[L-2:0], gelu_valid_in};
            pd[0] <= gelu_fn(gelu_data_in);
            for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
        end
    end
    assign gelu_valid_out = pv[L-1] | force_vo;
    assign gelu_data_out  = pd[L-1];

    int    n_pass  = 0;
    int    n_total = 0;
    string cur_tag = "init";

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s cyc=%0d: got %0h expected %0h", cur_tag, name, cyc, act, exp);
    endtask

    // Reference model: per-cycle expectations derived from the list of issue cycles.
    logic        e_rd  [MAXC];
    logic        e_vin [MAXC];
    logic        e_wr  [MAXC];
    logic [15:0] e_rda [MAXC];
    logic [15:0] e_wra [MAXC];
    logic [31:0] e_wrd [MAXC];
    int          e_done;
    logic        e_ab;

    task automatic build_model(input logic [15:0] src, input logic [15:0] dst, input int n,
                               input logic [63:0] hmask, input int acyc);
        int k = 0;
        int last = 0;
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 1'b0; e_vin[c] = 1'b0; e_wr[c] = 1'b0;
            e_rda[c] = '0; e_wra[c] = '0; e_wrd[c] = '0;
        end
        e_ab = 1'b0;
        if (n == 0) begin
            e_done = 1;
        end else begin
            for (int c = 1; c < 150 && k < n && !e_ab; c++) begin
                if (c == acyc) begin
                    e_ab   = 1'b1;
                    e_done = c + 2;
                end else if (!(c < 64 && hmask[c])) begin
                    e_rd[c]        = 1'b1;
                    e_rda[c]       = src + 16'(k);
                    e_vin[c+1]     = 1'b1;
                    e_wr[c+2+L]    = 1'b1;
                    e_wra[c+2+L]   = dst + 16'(k);
                    e_wrd[c+2+L]   = gelu_fn(sram_word(src + 16'(k)));
                    k++;
                    last = c;
                end
            end
            if (!e_ab) e_done = last + 3 + L;
            else if (k > 0 && last + 3 + L > e_done) e_done = last + 3 + L;
        end
    endtask

    task automatic run_job(input logic [15:0] src, input logic [15:0] dst, input int n,
                           input logic [63:0] hmask, input int acyc, input int rcyc,
                           output int done_cyc, output logic ab_seen, output int nrd, output int nwr);
        build_model(src, dst, n, hmask, acyc);
        done_cyc = -1; ab_seen = 1'b0; nrd = 0; nwr = 0;
        @(posedge clk); #1;
        start = 1'b1; src_base = src; dst_base = dst; len = 16'(n); hold = 1'b0; abort = 1'b0;
        for (int c = 1; c <= e_done + 1; c++) begin
            @(posedge clk); #1;
            start = (c == rcyc) && (rcyc <= e_done);
            if (start) begin
                src_base = ~src; dst_base = ~dst; len = 16'(n + 3);
            end
            hold  = (c < 64) ? hmask[c] : 1'b0;
            abort = (c == acyc);
            @(negedge clk);
            check("rd_en", c, rd_en, e_rd[c]);
            if (e_rd[c]) check("rd_addr", c, rd_addr, e_rda[c]);
            check("gelu_valid_in", c, gelu_valid_in, e_vin[c]);
            check("wr_en", c, wr_en, e_wr[c]);
            if (e_wr[c]) begin
                check("wr_addr", c, wr_addr, e_wra[c]);
                check("wr_data", c, wr_data, e_wrd[c]);
            end
            check("busy", c, busy, (n > 0) && (c < e_done));
            check("done", c, done, c == e_done);
            if (c == e_done) check("aborted", c, aborted, e_ab);
            if (rd_en) nrd++;
            if (wr_en) nwr++;
            if (done) begin
                done_cyc = c;
                ab_seen  = aborted;
            end
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0;
    endtask

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        int          n;
        logic [63:0] hmask;
        int          acyc;
        int          rcyc;
        int          exp_done;
        logic        exp_ab;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    initial begin
        vec_t tbl [10];
        int   dc, nr, nw;
        logic ab;

        tbl[0] = '{16'h0010, 16'h0100, 4, 64'h0,  0, 0, 11, 1'b0, 4, 4};
        tbl[1] = '{16'h0020, 16'h0200, 0, 64'h0,  0, 0,  1, 1'b0, 0, 0};
        tbl[2] = '{16'h0030, 16'h0300, 6, 64'hC,  0, 0, 15, 1'b0, 6, 6};
        tbl[3] = '{16'h0040, 16'h0400, 8, 64'h0,  3, 0,  9, 1'b1, 2, 2};
        tbl[4] = '{16'hFFFE, 16'h0500, 3, 64'h0,  0, 2, 10, 1'b0, 3, 3};
        tbl[5] = '{16'h0050, 16'h0600, 5, 64'h0,  1, 0,  3, 1'b1, 0, 0};
        tbl[6] = '{16'h0060, 16'h0700, 4, 64'h3E, 3, 0,  5, 1'b1, 0, 0};
        tbl[7] = '{16'h0070, 16'hFFFF, 2, 64'h0,  0, 0,  9, 1'b0, 2, 2};
        tbl[8] = '{16'h0080, 16'h0800, 3, 64'h0,  5, 0, 10, 1'b0, 3, 3};
        tbl[9] = '{16'h0090, 16'h0900, 1, 64'h0,  0, 1,  8, 1'b0, 1, 1};

        rst = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; len = '0;
        hold = 1'b0; abort = 1'b0; force_vo = 1'b0; rd_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cur_tag = "reset";
        check("busy", 0, busy, 1'b0);
        check("done", 0, done, 1'b0);
        check("aborted", 0, aborted, 1'b0);
        check("err", 0, err, 1'b0);
        check("rd_en", 0, rd_en, 1'b0);
        check("gelu_valid_in", 0, gelu_valid_in, 1'b0);
        check("wr_en", 0, wr_en, 1'b0);
        check("rd_addr", 0, rd_addr, 16'h0);
        check("wr_addr", 0, wr_addr, 16'h0);
        check("wr_data", 0, wr_data, 32'h0);

        for (int i = 0; i < 10; i++) begin
            cur_tag = $sformatf("tbl%0d", i);
            run_job(tbl[i].src, tbl[i].dst, tbl[i].n, tbl[i].hmask, tbl[i].acyc, tbl[i].rcyc, dc, ab, nr, nw);
            check("done_cycle", i, dc, tbl[i].exp_done);
            check("aborted_flag", i, ab, tbl[i].exp_ab);
            check("read_count", i, nr, tbl[i].exp_rd);
            check("write_count", i, nw, tbl[i].exp_wr);
        end

        for (int j = 0; j < 30; j++) begin
            logic [63:0] hm;
            int          ac;
            cur_tag = $sformatf("rand%0d", j);
            hm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
            run_job(16'($urandom), 16'($urandom), int'($urandom_range(0, 20)), hm, ac,
                    int'($urandom_range(1, 12)), dc, ab, nr, nw);
            check("done_cycle", j, dc, e_done);
        end

        cur_tag = "err";
        @(posedge clk); #1 force_vo = 1'b1;
        @(negedge clk);
        check("err_before", 0, err, 1'b0);
        @(posedge clk); #1 force_vo = 1'b0;
        @(negedge clk);
        check("err_set", 1, err, 1'b1);
        check("wr_en_suppressed", 1, wr_en, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("err_sticky", 6, err, 1'b1);
        check("wr_en_idle", 6, wr_en, 1'b0);

        cur_tag = "rst_mid";
        @(posedge clk); #1;
        start = 1'b1; src_base = 16'h0A00; dst_base = 16'h0B00; len = 16'd5;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("busy_before_rst", 3, busy, 1'b1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("busy", 4, busy, 1'b0);
        check("done", 4, done, 1'b0);
        check("aborted", 4, aborted, 1'b0);
        check("err_cleared", 4, err, 1'b0);
        check("rd_en", 4, rd_en, 1'b0);
        check("gelu_valid_in", 4, gelu_valid_in, 1'b0);
        check("wr_en", 4, wr_en, 1'b0);
        check("rd_addr", 4, rd_addr, 16'h0);
        check("wr_addr", 4, wr_addr, 16'h0);
        check("wr_data", 4, wr_data, 32'h0);
        for (int c = 5; c < 20; c++) begin
            @(negedge clk);
            check("no_done", c, done, 1'b0);
            check("no_wr", c, wr_en, 1'b0);
        end

        cur_tag = "post_rst";
        run_job(16'h0010, 16'h0100, 4, 64'h0, 0, 0, dc, ab, nr, nw);
        check("done_cycle", 0, dc, 11);
        check("write_count", 0, nw, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
